// File: rtl/reg_status_file.sv
// Architectural register file with rename status and ROB-tag to destination map.
// Optional same-cycle commit forwarding on the read ports: define REG_FILE_BYPASS_EN.
`timescale 1ns/1ps
module reg_status_file #(
    parameter int unsigned REG_NUM = 32,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned XLEN    = 32,
    localparam int unsigned IDX_W  = $clog2(REG_NUM),
    localparam int unsigned TAG_NUM = 2 ** TAG_W
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             issue_valid,
    input  logic [IDX_W-1:0] issue_rd,
    input  logic [TAG_W-1:0] issue_tag,
    input  logic [IDX_W-1:0] rs1_idx,
    input  logic [IDX_W-1:0] rs2_idx,
    output logic [XLEN-1:0]  rs1_val,
    output logic             rs1_busy,
    output logic [TAG_W-1:0] rs1_tag,
    output logic [XLEN-1:0]  rs2_val,
    output logic             rs2_busy,
    output logic [TAG_W-1:0] rs2_tag,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [XLEN-1:0]  cdb_val,
    input  logic             cdb_active,
    input  logic             predict_fail,
    output logic [31:0]      commit_cnt
);

    logic [XLEN-1:0]  r_regs    [REG_NUM];
    logic [TAG_W-1:0] r_reg_tag [REG_NUM];
    logic [IDX_W-1:0] r_tag_rd  [TAG_NUM];
    logic [REG_NUM-1:0] r_busy;
    logic [TAG_NUM-1:0] r_tag_vld;
    logic [31:0]        r_commit_cnt;

    logic [IDX_W-1:0] w_cm_rd;
    logic             w_cm_hit;

    // Commit lookup always uses the mapping as it stood before this cycle's issue.
    assign w_cm_rd  = r_tag_rd[cdb_tag];
    assign w_cm_hit = cdb_active && r_tag_vld[cdb_tag] && (w_cm_rd != '0);
    assign commit_cnt = r_commit_cnt;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_regs       <= '{default: '0};
            r_reg_tag    <= '{default: '0};
            r_tag_rd     <= '{default: '0};
            r_busy       <= '0;
            r_tag_vld    <= '0;
            r_commit_cnt <= '0;
        end else if (rdy_in) begin
            if (cdb_active) begin
                r_commit_cnt       <= r_commit_cnt + 32'd1;
                r_tag_vld[cdb_tag] <= 1'b0;
                if (w_cm_hit) begin
                    r_regs[w_cm_rd] <= cdb_val;
                    if (r_reg_tag[w_cm_rd] == cdb_tag) begin
                        r_busy[w_cm_rd] <= 1'b0;
                    end
                end
            end
            // Later assignments override the commit's busy/valid updates.
            if (predict_fail) begin
                r_busy    <= '0;
                r_tag_vld <= '0;
                r_reg_tag <= '{default: '0};
            end else if (issue_valid) begin
                r_tag_rd[issue_tag]  <= issue_rd;
                r_tag_vld[issue_tag] <= 1'b1;
                if (issue_rd != '0) begin
                    r_busy[issue_rd]    <= 1'b1;
                    r_reg_tag[issue_rd] <= issue_tag;
                end
            end
        end
    end

    // Read port: {val, busy, tag}; x0 is hard-wired to zero and never busy.
    function automatic logic [XLEN+TAG_W:0] f_read(input logic [IDX_W-1:0] idx);
        logic [XLEN-1:0]  val;
        logic             busy;
        logic [TAG_W-1:0] tag;
        val  = '0;
        busy = 1'b0;
        tag  = '0;
        if (idx != '0) begin
            val  = r_regs[idx];
            busy = r_busy[idx];
            tag  = busy ? r_reg_tag[idx] : '0;
`ifdef REG_FILE_BYPASS_EN
            if (cdb_active && rdy_in && busy && (r_reg_tag[idx] == cdb_tag)) begin
                val  = cdb_val;
                busy = 1'b0;
                tag  = '0;
            end
`endif
        end
        return {val, busy, tag};
    endfunction

    always_comb begin
        {rs1_val, rs1_busy, rs1_tag} = f_read(rs1_idx);
    end

    always_comb begin
        {rs2_val, rs2_busy, rs2_tag} = f_read(rs2_idx);
    end

endmodule

// File: tb/tb_reg_status_file.sv
// Bench for reg_status_file: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_reg_status_file;

    logic        clk = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic [3:0]  issue_tag = '0;
    logic [4:0]  rs1_idx = '0;
    logic [4:0]  rs2_idx = '0;
    logic [31:0] rs1_val, rs2_val;
    logic        rs1_busy, rs2_busy;
    logic [3:0]  rs1_tag, rs2_tag;
    logic [3:0]  cdb_tag = '0;
    logic [31:0] cdb_val = '0;
    logic        cdb_active = 1'b0;
    logic        predict_fail = 1'b0;
    logic [31:0] commit_cnt;

    int n_vec = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    reg_status_file dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_tag(issue_tag),
        .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
        .rs1_val(rs1_val), .rs1_busy(rs1_busy), .rs1_tag(rs1_tag),
        .rs2_val(rs2_val), .rs2_busy(rs2_busy), .rs2_tag(rs2_tag),
        .cdb_tag(cdb_tag), .cdb_val(cdb_val), .cdb_active(cdb_active),
        .predict_fail(predict_fail), .commit_cnt(commit_cnt)
    );

    always #5 clk = ~clk;

    // Model: map[tag] is the destination register, or -1 when the tag is not in flight.
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    int          m_tag  [32];
    int          m_map  [16];
    logic [31:0] m_cnt;

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0; m_busy[i] = 0; m_tag[i] = 0;
        end
        for (int t = 0; t < 16; t++) m_map[t] = -1;
        m_cnt = '0;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_in);
        if (!rst_in) begin
            m_reset();
        end else if (rdy_in) begin
            if (cdb_active) begin
                int d;
                m_cnt = m_cnt + 1;
                d = m_map[cdb_tag];
                if (d > 0) begin
                    m_regs[d] = cdb_val;
                    if (m_tag[d] == int'(cdb_tag)) m_busy[d] = 0;
                end
                m_map[cdb_tag] = -1;
            end
            if (predict_fail) begin
                for (int i = 0; i < 32; i++) begin
                    m_busy[i] = 0; m_tag[i] = 0;
                end
                for (int t = 0; t < 16; t++) m_map[t] = -1;
            end else if (issue_valid) begin
                m_map[issue_tag] = int'(issue_rd);
                if (issue_rd != 0) begin
                    m_busy[issue_rd] = 1;
                    m_tag[issue_rd]  = int'(issue_tag);
                end
            end
        end
    end

    task automatic m_read(input logic [4:0] idx, output logic [31:0] val,
                          output logic busy, output logic [3:0] tag);
        val = '0; busy = 1'b0; tag = '0;
        if (idx != 0) begin
            val  = m_regs[idx];
            busy = m_busy[idx];
            tag  = busy ? 4'(m_tag[idx]) : 4'd0;
`ifdef REG_FILE_BYPASS_EN
            if (cdb_active && rdy_in && busy && m_tag[idx] == int'(cdb_tag)) begin
                val = cdb_val; busy = 1'b0; tag = '0;
            end
`endif
        end
    endtask

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, got, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    initial forever begin
        logic [31:0] ev;
        logic        eb;
        logic [3:0]  et;
        @(negedge clk);
        if (check_en) begin
            m_read(rs1_idx, ev, eb, et);
            cmp("rs1_val", rs1_val, ev);
            cmp("rs1_busy", 32'(rs1_busy), 32'(eb));
            cmp("rs1_tag", 32'(rs1_tag), 32'(et));
            m_read(rs2_idx, ev, eb, et);
            cmp("rs2_val", rs2_val, ev);
            cmp("rs2_busy", 32'(rs2_busy), 32'(eb));
            cmp("rs2_tag", 32'(rs2_tag), 32'(et));
            cmp("commit_cnt", commit_cnt, m_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0; cdb_active = 1'b0; predict_fail = 1'b0; rdy_in = 1'b1;
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic [3:0] tag);
        issue_valid = 1'b1; issue_rd = rd; issue_tag = tag;
    endtask

    task automatic do_commit(input logic [3:0] tag, input logic [31:0] val);
        cdb_active = 1'b1; cdb_tag = tag; cdb_val = val;
    endtask

    task automatic chk_rs1(input string nm, input logic [4:0] idx, input logic [31:0] v,
                           input logic b, input logic [3:0] t);
        rs1_idx = idx;
        #1;
        cmp({nm, "_val"}, rs1_val, v);
        cmp({nm, "_busy"}, 32'(rs1_busy), 32'(b));
        cmp({nm, "_tag"}, 32'(rs1_tag), 32'(t));
    endtask

    initial begin
        idle();
        rdy_in = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_in = 1'b1;
        check_en = 1'b1;

        // Reset state
        chk_rs1("rst_x5", 5'd5, 32'h0, 1'b0, 4'd0);
        cmp("rst_cnt", commit_cnt, 32'd0);

        // Rename then commit
        do_issue(5'd5, 4'd3); tick(); idle();
        chk_rs1("ren_x5", 5'd5, 32'h0, 1'b1, 4'd3);
        do_commit(4'd3, 32'hDEADBEEF);
`ifdef REG_FILE_BYPASS_EN
        chk_rs1("byp_x5", 5'd5, 32'hDEADBEEF, 1'b0, 4'd0);
`else
        chk_rs1("byp_x5", 5'd5, 32'h0, 1'b1, 4'd3);
`endif
        tick(); idle();
        chk_rs1("cm_x5", 5'd5, 32'hDEADBEEF, 1'b0, 4'd0);
        cmp("cm_cnt", commit_cnt, 32'd1);

        // Two renames of x7: older commit must not clear busy
        do_issue(5'd7, 4'd1); tick();
        do_issue(5'd7, 4'd2); tick(); idle();
        do_commit(4'd1, 32'h11); tick(); idle();
        chk_rs1("old_x7", 5'd7, 32'h11, 1'b1, 4'd2);
        do_commit(4'd2, 32'h22); tick(); idle();
        chk_rs1("new_x7", 5'd7, 32'h22, 1'b0, 4'd0);

        // x0 destination and never-issued tag
        do_issue(5'd0, 4'd4); tick(); idle();
        do_commit(4'd4, 32'hFF); tick(); idle();
        chk_rs1("x0", 5'd0, 32'h0, 1'b0, 4'd0);
        cmp("x0_cnt", commit_cnt, 32'd4);
        do_commit(4'd9, 32'h1234); tick(); idle();
        cmp("t9_cnt", commit_cnt, 32'd5);
        chk_rs1("t9_x7", 5'd7, 32'h22, 1'b0, 4'd0);

        // Flush with a same-cycle commit
        do_issue(5'd3, 4'd5); tick(); idle();
        do_commit(4'd5, 32'h55); tick(); idle();
        do_issue(5'd3, 4'd6); tick();
        do_issue(5'd8, 4'd7); tick(); idle();
        do_commit(4'd6, 32'h99); predict_fail = 1'b1; tick(); idle();
        chk_rs1("pf_x3", 5'd3, 32'h99, 1'b0, 4'd0);
        chk_rs1("pf_x8", 5'd8, 32'h0, 1'b0, 4'd0);
        cmp("pf_cnt", commit_cnt, 32'd7);
        do_commit(4'd7, 32'hAB); tick(); idle();
        chk_rs1("pf_t7", 5'd8, 32'h0, 1'b0, 4'd0);
        cmp("pf_t7_cnt", commit_cnt, 32'd8);

        // Pause holds all state
        do_issue(5'd12, 4'd8); do_commit(4'd8, 32'h42); rdy_in = 1'b0; tick(); idle();
        chk_rs1("rdy_x12", 5'd12, 32'h0, 1'b0, 4'd0);
        cmp("rdy_cnt", commit_cnt, 32'd8);

        // Same-cycle issue and commit to x10
        do_issue(5'd10, 4'd2); tick(); idle();
        do_issue(5'd10, 4'd5); do_commit(4'd2, 32'h77); tick(); idle();
        chk_rs1("ic_x10", 5'd10, 32'h77, 1'b1, 4'd5);
        cmp("ic_cnt", commit_cnt, 32'd9);

        // Asynchronous reset mid-operation
        #1 rst_in = 1'b0;
        chk_rs1("arst_x10", 5'd10, 32'h0, 1'b0, 4'd0);
        cmp("arst_cnt", commit_cnt, 32'd0);
        @(posedge clk); #1 rst_in = 1'b1;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int q[$];
            rdy_in       = ($urandom_range(0, 9) != 0);
            issue_valid  = $urandom_range(0, 1) == 1;
            issue_rd     = 5'($urandom_range(0, 31));
            issue_tag    = 4'($urandom_range(0, 15));
            cdb_active   = $urandom_range(0, 1) == 1;
            cdb_val      = $urandom;
            predict_fail = ($urandom_range(0, 24) == 0);
            rs1_idx      = 5'($urandom_range(0, 31));
            rs2_idx      = 5'($urandom_range(0, 31));
            for (int t = 0; t < 16; t++) if (m_map[t] >= 0) q.push_back(t);
            if (q.size() > 0 && $urandom_range(0, 3) != 0)
                cdb_tag = 4'(q[$urandom_range(0, q.size() - 1)]);
            else
                cdb_tag = 4'($urandom_range(0, 15));
            if (m_busy[rs1_idx] && $urandom_range(0, 2) == 0)
                cdb_tag = 4'(m_tag[rs1_idx]);
            tick();
        end
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_status_file.md
Name: reg_status_file

Overview:
- Architectural register file plus rename-status table; sits directly downstream of the reorder buffer.
- Consumes the ROB commit broadcast (cdb_tag/cdb_val/cdb_active) and retires values into the 32 architectural registers.
- The dispatcher marks a destination register busy with a ROB tag when issuing. It reads operands, together with their busy/tag status, through two combinational read ports.
- predict_fail drops all speculative rename state and keeps committed values.

Parameters:
- REG_NUM, 32: architectural register count; index width is 5.
- TAG_W, 4: ROB tag width; the tag table has 2^TAG_W entries.
- XLEN, 32: data width.

Ports:
- clk_in  input  1  clock, rising edge
- rst_in  input  1  asynchronous, active-low reset
- rdy_in  input  1  0 = pause; all state holds
- issue_valid  input  1  dispatch of one instruction this cycle
- issue_rd  input  5  destination register (0 = no writeback)
- issue_tag  input  TAG_W  ROB tag of the issued instruction
- rs1_idx  input  5  read port 1 index
- rs2_idx  input  5  read port 2 index
- rs1_val  output  XLEN  register value, or forwarded value
- rs1_busy  output  1  operand still pending
- rs1_tag  output  TAG_W  producing tag when busy, else 0
- rs2_val / rs2_busy / rs2_tag  output  XLEN / 1 / TAG_W  same as port 1
- cdb_tag  input  TAG_W  committing tag (from ROB head)
- cdb_val  input  XLEN  committing value
- cdb_active  input  1  commit this cycle
- predict_fail  input  1  flush speculative state
- commit_cnt  output  32  count of accepted commits (wraps)

Behaviour:
- State:
  - regs[32] x XLEN.
  - busy[32], reg_tag[32] x TAG_W.
  - tag_rd[2^TAG_W] x 5 with tag_vld[2^TAG_W]: maps ROB tag to destination register.
  - commit_cnt.
- Reset (rst_in=0, async): all regs, busy, reg_tag, tag_rd, tag_vld and commit_cnt clear to 0. Read outputs therefore read 0/0/0.
- rdy_in=0: no state update; read ports stay live.
- Issue (issue_valid, rdy_in, !predict_fail):
  - tag_rd[issue_tag] <= issue_rd; tag_vld[issue_tag] <= 1.
  - If issue_rd != 0: busy[rd] <= 1 and reg_tag[rd] <= issue_tag.
  - issue_rd == 0 records tag_vld but never marks x0.
- Commit (cdb_active, rdy_in):
  - Lookup d = tag_rd[cdb_tag]. If tag_vld[cdb_tag] and d != 0: regs[d] <= cdb_val.
  - Clear busy[d] only when reg_tag[d] == cdb_tag; a newer renamer keeps busy.
  - tag_vld[cdb_tag] <= 0. commit_cnt increments by 1 on every accepted commit, including commits with an invalid tag.
  - A commit whose tag_vld is 0 writes nothing.
- Same-cycle issue and commit to the same rd: the value is written, busy ends at 1, and reg_tag takes issue_tag (issue wins over the busy clear).
- Same tag issued and committed in one cycle (tag reuse): commit uses the old mapping; the issue then installs the new mapping.
- predict_fail (with rdy_in):
  - The commit in the same cycle is still applied to regs and commit_cnt, since the ROB head is architectural.
  - Then all busy and tag_vld clear and reg_tag is zeroed.
  - Issue in that cycle is ignored. Register values are retained.
- Read ports (combinational, latency 0):
  - Index 0 always returns 0, not busy, tag 0.
  - Otherwise return regs, busy and reg_tag, modified by forwarding (see Optional Feature).
  - rs_tag is 0 whenever rs_busy is 0.
- Reads do not see same-cycle issue; the dispatcher handles intra-cycle dependencies.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined: when cdb_active, rdy_in, rs busy, and reg_tag == cdb_tag, the read port returns val = cdb_val, busy = 0, tag = 0 in the same cycle.
- Undefined: read ports show stored state only; the operand becomes ready the cycle after commit.

Test Plan:
- Reset, then read x5 -> 0/busy 0/tag 0; commit_cnt 0. Assert rst_in low mid-operation -> everything back to 0 immediately.
- Issue rd=5 tag=3; next cycle read x5 -> busy 1, tag 3. Commit tag=3 val=0xDEADBEEF -> next cycle x5=0xDEADBEEF, busy 0, commit_cnt=1. Same-cycle read returns the forwarded value only with REG_FILE_BYPASS_EN.
- Issue rd=7 tag=1, then rd=7 tag=2. Commit tag 1 val=0x11 -> x7=0x11, still busy, tag 2. Commit tag 2 val=0x22 -> x7=0x22, not busy.
- Issue rd=0 tag=4, commit tag 4 val=0xFF -> x0 reads 0, commit_cnt increments. Commit of never-issued tag 9 -> no register change, commit_cnt increments.
- Issue rd=3 tag=6 and rd=8 tag=7 (x3 was previously committed 0x55). predict_fail together with commit of tag 6 val=0x99 -> x3=0x99, x3 and x8 not busy, tag 7 mapping gone; a later commit of tag 7 writes nothing.
- rdy_in=0 with issue_valid and cdb_active asserted -> no state or commit_cnt change. Issue and commit to rd=10 in the same cycle (old tag 2, new tag 5) -> x10 = cdb_val, busy 1, tag 5.
